// File: rtl/sorted_stream_merge.sv
// Merges two ascending-sorted stream packets into one ascending packet, ties to A.
// Latency: one cycle from input accept to registered output beat.
// Backpressure: a stalled output (valid && !ready) holds its beat and drops both input readies.
module sorted_stream_merge #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_tvalid,
    output logic                  a_tready,
    input  logic [DATA_WIDTH-1:0] a_tdata,
    input  logic                  a_tlast,
    input  logic                  b_tvalid,
    output logic                  b_tready,
    input  logic [DATA_WIDTH-1:0] b_tdata,
    input  logic                  b_tlast,
    output logic                  dest_tvalid,
    input  logic                  dest_tready,
    output logic [DATA_WIDTH-1:0] dest_tdata,
    output logic                  dest_tlast,
    output logic [CNT_WIDTH-1:0]  dest_len,
    output logic                  order_err
);

    typedef enum logic [1:0] {
        MERGE   = 2'd0,
        DRAIN_A = 2'd1,
        DRAIN_B = 2'd2
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] dat;
    } beat_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  len_cnt;
    logic [DATA_WIDTH-1:0] a_prev;
    logic [DATA_WIDTH-1:0] b_prev;
    logic                  a_first;
    logic                  b_first;

    logic  load_ok;
    logic  a_le_b;
    logic  a_acc;
    logic  b_acc;
    logic  any_acc;
    logic  a_bad;
    logic  b_bad;
    beat_t sel;

    assign load_ok = !dest_tvalid || dest_tready;
    assign a_le_b  = a_tdata <= b_tdata;

    // Each ready depends on the other stream's valid in MERGE, so both sides
    // must be present before the compare result is trusted.
    assign a_tready = rst && load_ok &&
                      ((state == DRAIN_A) || ((state == MERGE) && b_tvalid && a_le_b));
    assign b_tready = rst && load_ok &&
                      ((state == DRAIN_B) || ((state == MERGE) && a_tvalid && !a_le_b));

    assign a_acc   = a_tvalid && a_tready;
    assign b_acc   = b_tvalid && b_tready;
    assign any_acc = a_acc || b_acc;

    assign a_bad = a_acc && !a_first && (a_tdata < a_prev);
    assign b_bad = b_acc && !b_first && (b_tdata < b_prev);

    always_comb begin
        sel.dat  = b_tdata;
        sel.last = b_tlast && (state == DRAIN_B);
        if (a_acc) begin
            sel.dat  = a_tdata;
            sel.last = a_tlast && (state == DRAIN_A);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MERGE;
        end else begin
            case (state)
                MERGE: begin
                    if (a_acc && a_tlast) begin
                        state <= DRAIN_B;
                    end else if (b_acc && b_tlast) begin
                        state <= DRAIN_A;
                    end
                end
                DRAIN_A: begin
                    if (a_acc && a_tlast) begin
                        state <= MERGE;
                    end
                end
                DRAIN_B: begin
                    if (b_acc && b_tlast) begin
                        state <= MERGE;
                    end
                end
                default: state <= MERGE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dest_tvalid <= 1'b0;
            dest_tdata  <= '0;
            dest_tlast  <= 1'b0;
        end else if (any_acc) begin
            dest_tvalid <= 1'b1;
            dest_tdata  <= sel.dat;
            dest_tlast  <= sel.last;
        end else if (dest_tready) begin
            dest_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_cnt  <= '0;
            dest_len <= '0;
        end else if (any_acc) begin
            if (sel.last) begin
                dest_len <= len_cnt + CNT_WIDTH'(1);
                len_cnt  <= '0;
            end else begin
                len_cnt  <= len_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // First-element flags re-arm on each port's tlast so a new packet may start low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_prev    <= '0;
            b_prev    <= '0;
            a_first   <= 1'b1;
            b_first   <= 1'b1;
            order_err <= 1'b0;
        end else begin
            order_err <= a_bad || b_bad;
            if (a_acc) begin
                a_prev  <= a_tdata;
                a_first <= a_tlast;
            end
            if (b_acc) begin
                b_prev  <= b_tdata;
                b_first <= b_tlast;
            end
        end
    end

endmodule

// File: tb/tb_sorted_stream_merge.sv
// Directed bench for sorted_stream_merge: merge, ties, skew, back-pressure, order error, reset.
module tb_sorted_stream_merge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_tvalid = 1'b0;
    logic        a_tready;
    logic [7:0]  a_tdata = 8'h0;
    logic        a_tlast = 1'b0;
    logic        b_tvalid = 1'b0;
    logic        b_tready;
    logic [7:0]  b_tdata = 8'h0;
    logic        b_tlast = 1'b0;
    logic        dest_tvalid;
    logic        dest_tready = 1'b0;
    logic [7:0]  dest_tdata;
    logic        dest_tlast;
    logic [13:0] dest_len;
    logic        order_err;

    int total = 0;
    int bad   = 0;

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    bit          rdy_pat[$];
    logic [7:0]  got_dat[$];
    logic        got_last[$];
    logic [13:0] got_len;
    int          err_cyc[$];
    int          acc_a_cyc[$];
    byte         acc_src[$];
    int          first_out;
    int          last_out;
    bit          drainb_seen;

    sorted_stream_merge #(.DATA_WIDTH(8), .CNT_WIDTH(14)) dut (
        .clk(clk), .rst(rst),
        .a_tvalid(a_tvalid), .a_tready(a_tready), .a_tdata(a_tdata), .a_tlast(a_tlast),
        .b_tvalid(b_tvalid), .b_tready(b_tready), .b_tdata(b_tdata), .b_tlast(b_tlast),
        .dest_tvalid(dest_tvalid), .dest_tready(dest_tready), .dest_tdata(dest_tdata),
        .dest_tlast(dest_tlast), .dest_len(dest_len), .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic clear_log();
        got_dat.delete();
        got_last.delete();
        err_cyc.delete();
        acc_a_cyc.delete();
        acc_src.delete();
        got_len     = '0;
        first_out   = -1;
        last_out    = -1;
        drainb_seen = 1'b0;
    endtask

    // Drives qa/qb as one packet each, logs output transfers, and checks stall behaviour.
    task automatic drive(input int n_out, input int max_acc);
        int         cyc = 0;
        int         acc = 0;
        bit         stalled = 1'b0;
        logic [7:0] held = '0;
        bit         a_acc;
        bit         b_acc;
        while (got_dat.size() < n_out && acc < max_acc && cyc < 200) begin
            @(negedge clk);
            a_tvalid    = qa.size() > 0;
            a_tdata     = (qa.size() > 0) ? qa[0] : 8'h0;
            a_tlast     = qa.size() == 1;
            b_tvalid    = qb.size() > 0;
            b_tdata     = (qb.size() > 0) ? qb[0] : 8'h0;
            b_tlast     = qb.size() == 1;
            dest_tready = rdy_pat[cyc % rdy_pat.size()];
            #1;
            if (order_err === 1'b1) err_cyc.push_back(cyc);
            if (stalled) begin
                total++;
                if (dest_tdata !== held) begin
                    bad++;
                    $display("FAIL stall_hold cyc=%0d: got %0d want %0d", cyc, dest_tdata, held);
                end
            end
            stalled = (dest_tvalid === 1'b1) && !dest_tready;
            held    = dest_tdata;
            if (stalled) begin
                total++;
                if ({a_tready, b_tready} !== 2'b00) begin
                    bad++;
                    $display("FAIL stall_ready cyc=%0d: got %b want 00", cyc, {a_tready, b_tready});
                end
            end
            if (dest_tvalid === 1'b1 && dest_tready) begin
                got_dat.push_back(dest_tdata);
                got_last.push_back(dest_tlast);
                if (dest_tlast === 1'b1) got_len = dest_len;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (!a_tvalid && b_tvalid && b_tready === 1'b1) drainb_seen = 1'b1;
            a_acc = a_tvalid && (a_tready === 1'b1);
            b_acc = b_tvalid && (b_tready === 1'b1);
            @(posedge clk);
            if (a_acc) begin
                void'(qa.pop_front());
                acc_a_cyc.push_back(cyc);
                acc_src.push_back("A");
                acc++;
            end
            if (b_acc) begin
                void'(qb.pop_front());
                acc_src.push_back("B");
                acc++;
            end
            cyc++;
        end
        if (cyc >= 200) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d beats want %0d", got_dat.size(), n_out);
        end
        @(negedge clk);
        a_tvalid    = 1'b0;
        b_tvalid    = 1'b0;
        a_tlast     = 1'b0;
        b_tlast     = 1'b0;
        dest_tready = 1'b1;
    endtask

    task automatic test_reset();
        a_tvalid    = 1'b1;
        b_tvalid    = 1'b1;
        dest_tready = 1'b1;
        a_tdata     = 8'd3;
        b_tdata     = 8'd4;
        #1;
        total++;
        if ({dest_tvalid, dest_tdata, dest_tlast, dest_len, order_err} !== 25'h0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b d=%0d l=%b len=%0d e=%b want all 0",
                     dest_tvalid, dest_tdata, dest_tlast, dest_len, order_err);
        end
        total++;
        if ({a_tready, b_tready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready: got %b want 00", {a_tready, b_tready});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        rst      = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] exp[6];
        exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd10};
        clear_log();
        qa = '{8'd1, 8'd4, 8'd9};
        qb = '{8'd2, 8'd3, 8'd10};
        rdy_pat = '{1'b1};
        drive(6, 1000);
        total++;
        if (got_dat.size() !== 6) begin
            bad++;
            $display("FAIL basic_count: got %0d want 6", got_dat.size());
        end
        for (int i = 0; i < 6 && i < got_dat.size(); i++) begin
            total++;
            if (got_dat[i] !== exp[i] || got_last[i] !== (i == 5)) begin
                bad++;
                $display("FAIL basic_beat%0d: got %0d/last=%b want %0d/last=%b",
                         i, got_dat[i], got_last[i], exp[i], i == 5);
            end
        end
        total++;
        if (got_len !== 14'd6) begin
            bad++;
            $display("FAIL basic_len: got %0d want 6", got_len);
        end
        total++;
        if (last_out - first_out !== 5) begin
            bad++;
            $display("FAIL basic_throughput: got span %0d want 5", last_out - first_out);
        end
    endtask

    task automatic test_ties();
        clear_log();
        qa = '{8'd5, 8'd5};
        qb = '{8'd5};
        rdy_pat = '{1'b1};
        drive(3, 1000);
        for (int i = 0; i < 3 && i < got_dat.size(); i++) begin
            total++;
            if (got_dat[i] !== 8'd5 || got_last[i] !== (i == 2)) begin
                bad++;
                $display("FAIL ties_beat%0d: got %0d/last=%b want 5/last=%b",
                         i, got_dat[i], got_last[i], i == 2);
            end
        end
        total++;
        if (acc_src.size() !== 3 || acc_src[0] !== "A" || acc_src[1] !== "A" || acc_src[2] !== "B") begin
            bad++;
            $display("FAIL ties_order: got %0d accepts want A,A,B", acc_src.size());
        end
        total++;
        if (drainb_seen !== 1'b1) begin
            bad++;
            $display("FAIL ties_drain_b: got %b want 1", drainb_seen);
        end
    endtask

    task automatic test_unequal();
        logic [7:0] exp[5];
        exp = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd8};
        clear_log();
        qa = '{8'd7};
        qb = '{8'd1, 8'd2, 8'd3, 8'd8};
        rdy_pat = '{1'b1};
        drive(5, 1000);
        for (int i = 0; i < 5 && i < got_dat.size(); i++) begin
            total++;
            if (got_dat[i] !== exp[i] || got_last[i] !== (i == 4)) begin
                bad++;
                $display("FAIL unequal_beat%0d: got %0d/last=%b want %0d/last=%b",
                         i, got_dat[i], got_last[i], exp[i], i == 4);
            end
        end
        total++;
        if (got_dat.size() !== 5 || got_len !== 14'd5) begin
            bad++;
            $display("FAIL unequal_len: got %0d beats len %0d want 5 beats len 5",
                     got_dat.size(), got_len);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[6];
        exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd10};
        clear_log();
        qa = '{8'd1, 8'd4, 8'd9};
        qb = '{8'd2, 8'd3, 8'd10};
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        drive(6, 1000);
        total++;
        if (got_dat.size() !== 6) begin
            bad++;
            $display("FAIL bp_count: got %0d want 6", got_dat.size());
        end
        for (int i = 0; i < 6 && i < got_dat.size(); i++) begin
            total++;
            if (got_dat[i] !== exp[i] || got_last[i] !== (i == 5)) begin
                bad++;
                $display("FAIL bp_beat%0d: got %0d/last=%b want %0d/last=%b",
                         i, got_dat[i], got_last[i], exp[i], i == 5);
            end
        end
        total++;
        if (got_len !== 14'd6) begin
            bad++;
            $display("FAIL bp_len: got %0d want 6", got_len);
        end
    endtask

    task automatic test_order_err();
        logic [7:0] exp[3];
        exp = '{8'd3, 8'd2, 8'd9};
        clear_log();
        qa = '{8'd3, 8'd2};
        qb = '{8'd9};
        rdy_pat = '{1'b1};
        drive(3, 1000);
        for (int i = 0; i < 3 && i < got_dat.size(); i++) begin
            total++;
            if (got_dat[i] !== exp[i]) begin
                bad++;
                $display("FAIL order_beat%0d: got %0d want %0d", i, got_dat[i], exp[i]);
            end
        end
        total++;
        if (err_cyc.size() !== 1 || acc_a_cyc.size() !== 2 || err_cyc[0] !== acc_a_cyc[1] + 1) begin
            bad++;
            $display("FAIL order_pulse: got %0d pulses want 1 on cycle after second A accept",
                     err_cyc.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] exp[6];
        exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd10};
        clear_log();
        qa = '{8'd1, 8'd4, 8'd9};
        qb = '{8'd2, 8'd3, 8'd10};
        rdy_pat = '{1'b1};
        drive(100, 2);
        a_tvalid = 1'b1;
        b_tvalid = 1'b1;
        rst = 1'b0;
        #1;
        total++;
        if ({dest_tvalid, dest_tdata, dest_tlast, dest_len, order_err} !== 25'h0) begin
            bad++;
            $display("FAIL midrst_outputs: got v=%b d=%0d l=%b len=%0d want all 0",
                     dest_tvalid, dest_tdata, dest_tlast, dest_len);
        end
        total++;
        if ({a_tready, b_tready} !== 2'b00) begin
            bad++;
            $display("FAIL midrst_ready: got %b want 00", {a_tready, b_tready});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        rst      = 1'b1;
        clear_log();
        qa = '{8'd1, 8'd4, 8'd9};
        qb = '{8'd2, 8'd3, 8'd10};
        drive(6, 1000);
        for (int i = 0; i < 6 && i < got_dat.size(); i++) begin
            total++;
            if (got_dat[i] !== exp[i] || got_last[i] !== (i == 5)) begin
                bad++;
                $display("FAIL midrst_beat%0d: got %0d/last=%b want %0d/last=%b",
                         i, got_dat[i], got_last[i], exp[i], i == 5);
            end
        end
        total++;
        if (got_dat.size() !== 6 || got_len !== 14'd6) begin
            bad++;
            $display("FAIL midrst_len: got %0d beats len %0d want 6 beats len 6",
                     got_dat.size(), got_len);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_unequal();
        test_backpressure();
        test_order_err();
        test_reset_mid_packet();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sorted_stream_merge.md
# sorted_stream_merge

Two-input merge stage that sits directly downstream of a pair of `insertion_sort` instances. It consumes two ascending-sorted AXI-Stream packets and emits one ascending-sorted packet containing every element of both. This lets two sorters of depth 2**ADDR_WIDTH produce sorted runs of up to 2*2**ADDR_WIDTH elements. A one-entry output register gives full-throughput, one-cycle-latency operation and breaks the combinational path from `dest_tready` to the data compare.

## Interface
- DATA_WIDTH, 8, element width; unsigned compare.
- CNT_WIDTH, 14, width of the output packet length counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronous to `clk` upstream.
- a_tvalid  in  1  stream A valid.
- a_tready  out  1  stream A ready.
- a_tdata  in  DATA_WIDTH  stream A element; ascending within a packet.
- a_tlast  in  1  last element of the A packet.
- b_tvalid, b_tready, b_tdata, b_tlast: same meaning as the A signals, for stream B.
- dest_tvalid  out  1  output valid (registered).
- dest_tready  in  1  output ready.
- dest_tdata  out  DATA_WIDTH  merged element (registered).
- dest_tlast  out  1  last element of the merged packet (registered).
- dest_len  out  CNT_WIDTH  element count of the last completed packet; updated with the beat carrying dest_tlast.
- order_err  out  1  one-cycle registered pulse: an accepted input element was smaller than the previous accepted element on the same port within the same packet.

## Operation
- Each merged packet consumes exactly one A packet and one B packet. Both input packets must be non-empty.
- The state machine has three states:
  - MERGE (reset state): both packets still have elements to deliver.
    - Accept is decided only when a_tvalid && b_tvalid; if either is low, accept nothing.
    - If a_tdata <= b_tdata, accept A; otherwise accept B. Ties go to A.
    - Accepting A with a_tlast moves to DRAIN_B. Accepting B with b_tlast moves to DRAIN_A.
  - DRAIN_A: B is finished. Pass A through, gated only by a_tvalid. Accepting A with a_tlast returns to MERGE.
  - DRAIN_B: mirror of DRAIN_A.
- At most one input beat is accepted per cycle. a_tready and b_tready are never both high.
- Output register load condition: load_ok = !dest_tvalid || dest_tready.
  - a_tready = rst && load_ok && (DRAIN_A || (MERGE && b_tvalid && a_tdata <= b_tdata)).
  - b_tready follows symmetrically, using a_tdata > b_tdata.
- On an accepted beat:
  - dest_tdata takes the selected data.
  - dest_tvalid goes to 1.
  - dest_tlast = 1 only for a tlast beat accepted in a DRAIN state.
- If dest_tready is high and no beat is accepted, dest_tvalid clears.
- Length counter:
  - len_cnt increments on each accepted beat.
  - On the dest_tlast beat, dest_len takes len_cnt + 1 and len_cnt clears.
  - The counter wraps modulo 2**CNT_WIDTH.
- Order check: per-port last-accepted value registers, plus a per-port "first element" flag that is set at reset and after that port's tlast. order_err pulses on the cycle after an accepted beat whose data is smaller than the stored value, with the first-element flag clear. Data still passes through unchanged.

## Timing
- Latency: input accept at edge N gives dest_tvalid/dest_tdata valid after edge N.
- Throughput: one element per cycle while dest_tready = 1 and the needed input is valid.
- Back-pressure: with dest_tvalid = 1 and dest_tready = 0, both readies are 0 and the output holds stable.
- Reset (rst = 0), effective immediately and asynchronously:
  - dest_tvalid = 0, dest_tdata = 0, dest_tlast = 0, dest_len = 0, order_err = 0.
  - state = MERGE, len_cnt = 0, first-element flags = 1.
  - a_tready = b_tready = 0 for as long as rst = 0.
- Reset mid-packet: partial packets are discarded. After release, the next beats are treated as new packet starts.
- A tlast in MERGE never produces dest_tlast; dest_tlast appears only after the other stream's tlast.
- Mid-packet stall on the needed input in MERGE: the output drains, dest_tvalid goes to 0, and the state holds.

## Test plan
- Basic merge: A = {1,4,9}, B = {2,3,10}, dest_tready = 1 → dest = 1,2,3,4,9,10; tlast on 10; dest_len = 6; one beat per cycle.
- Ties and skew: A = {5,5}, B = {5}.
  - Expect dest = 5(A), 5(A), 5(B), with tlast on the B beat.
  - Expect DRAIN_B entered after the second A beat.
- Unequal lengths: A = {7}, B = {1,2,3,8} → dest = 1,2,3,7,8; A is exhausted first; tlast on 8; dest_len = 5.
- Back-pressure: same stimulus as basic merge, with dest_tready toggling 1,0,0,1,… → identical output sequence; dest_tdata stable while stalled; readies low while stalled.
- Order error: A = {3,2}, B = {9} → order_err pulses exactly once, on the cycle after 2 is accepted; output 3,2,9.
- Reset mid-packet: assert rst after 2 beats of basic merge → outputs zero immediately. After release, the full A = {1,4,9}, B = {2,3,10} produces a correct 6-beat packet with dest_len = 6.
